display_mode_ctrl: RTL

DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

---
 rtl/disp_pkg.sv | 42 ++++
 rtl/edge_detect.sv | 33 +++
 rtl/display_mode_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display mode controller.
// DISP_IDLE_BLANK_EN adds the BLANK state used for inactivity blanking.
package disp_pkg;

   localparam int HOLD_W = 4;
   localparam int IDLE_W = 6;

   typedef enum logic [1:0] {
      SEL_BLANK = 2'd0,
      SEL_SW    = 2'd1,
      SEL_TMR   = 2'd2,
      SEL_MEM   = 2'd3
   } disp_sel_t;

   typedef enum logic [1:0] {
      ST_SW  = 2'd0,
      ST_TMR = 2'd1,
      ST_MEM = 2'd2
`ifdef DISP_IDLE_BLANK_EN
      , ST_BLANK = 2'd3
`endif
   } state_t;

   // Saved view bit: 0 = stopwatch, 1 = timer.
   function automatic state_t view_state(input logic view);
      return view ? ST_TMR : ST_SW;
   endfunction

   function automatic disp_sel_t sel_of(input state_t s);
      disp_sel_t sel;
      case (s)
         ST_TMR:   sel = SEL_TMR;
         ST_MEM:   sel = SEL_MEM;
`ifdef DISP_IDLE_BLANK_EN
         ST_BLANK: sel = SEL_BLANK;
`endif
         default:  sel = SEL_SW;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registered one-cycle pulse in the cycle after a
// 0->1 transition is sampled. History clears to 0 on reset, so a level
// already high at reset release yields an event.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic evt
);

   logic prev_q, prev_d;
   logic evt_q, evt_d;

   // Next history and pulse.
   always_comb begin
      prev_d = din;
      evt_d  = din & ~prev_q;
   end

   // History and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
         evt_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         evt_q  <= evt_d;
      end
   end

   assign evt = evt_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Display mode controller: stopwatch/timer view toggle, timed memory view,
// timer-expiry alert with blinking, optional inactivity blanking
// (enabled by defining DISP_IDLE_BLANK_EN).
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_SW    | showing stopwatch
// ST_TMR   | showing timer
// ST_MEM   | showing memory, hold counter runs on 1 Hz strobe
// ST_BLANK | display blanked after inactivity (optional build)
module display_mode_ctrl
   import disp_pkg::*;
#(
   parameter int MEM_HOLD_SEC = 3,
   parameter int IDLE_SEC     = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       recall_btn,
   input  logic       timer_expired,
   input  logic       strobe_1hz,
   output logic [1:0] output_select,
   output logic       alert,
   output logic       display_en
);

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MEM_HOLD_SEC);

   logic mode_evt, recall_evt, tmr_evt;

   edge_detect u_mode_edge   (.clk(clk), .rst(rst), .din(mode_btn),      .evt(mode_evt));
   edge_detect u_recall_edge (.clk(clk), .rst(rst), .din(recall_btn),    .evt(recall_evt));
   edge_detect u_tmr_edge    (.clk(clk), .rst(rst), .din(timer_expired), .evt(tmr_evt));

   state_t            state_q, state_d;
   disp_sel_t         sel_q, sel_d;
   logic              saved_q, saved_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              alert_q, alert_d;
   logic              disp_en_q, disp_en_d;

`ifdef DISP_IDLE_BLANK_EN
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_SEC);
   logic [IDLE_W-1:0] idle_q, idle_d;
`else
   logic unused_idle_sec;
   assign unused_idle_sec = (IDLE_SEC != 0);
`endif

   // Next state: background strobe effects first, then prioritized events override.
   always_comb begin
      state_d   = state_q;
      saved_d   = saved_q;
      hold_d    = hold_q;
      alert_d   = alert_q;
      disp_en_d = disp_en_q;
`ifdef DISP_IDLE_BLANK_EN
      idle_d    = idle_q;
`endif

      if (strobe_1hz && state_q == ST_MEM) begin
         if (hold_q == HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = view_state(saved_q);
         end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
         end
      end

      if (strobe_1hz && alert_q)
         disp_en_d = ~disp_en_q;

`ifdef DISP_IDLE_BLANK_EN
      if (strobe_1hz && !mode_evt && !recall_evt && !alert_q && idle_q != '1)
         idle_d = idle_q + 1'b1;
      if ((state_q == ST_SW || state_q == ST_TMR) && idle_d >= IDLE_LIM) begin
         saved_d = (state_q == ST_TMR);
         state_d = ST_BLANK;
         idle_d  = '0;
      end
`endif

      if (tmr_evt) begin
         state_d   = ST_TMR;
         alert_d   = 1'b1;
         disp_en_d = 1'b1;
         hold_d    = '0;
`ifdef DISP_IDLE_BLANK_EN
         idle_d    = '0;
`endif
      end else if (recall_evt || mode_evt) begin
`ifdef DISP_IDLE_BLANK_EN
         idle_d = '0;
`endif
         if (alert_q) begin
            // Press only acknowledges the alert; view stays put.
            alert_d   = 1'b0;
            disp_en_d = 1'b1;
            state_d   = state_q;
            hold_d    = hold_q;
         end else if (recall_evt) begin
            case (state_q)
               ST_SW, ST_TMR: begin
                  saved_d = (state_q == ST_TMR);
                  state_d = ST_MEM;
                  hold_d  = HOLD_LOAD;
               end
               ST_MEM: begin
                  state_d = ST_MEM;
                  hold_d  = HOLD_LOAD;
               end
`ifdef DISP_IDLE_BLANK_EN
               ST_BLANK: state_d = view_state(saved_q);
`endif
               default: state_d = ST_SW;
            endcase
         end else begin
            case (state_q)
               ST_SW:  state_d = ST_TMR;
               ST_TMR: state_d = ST_SW;
               ST_MEM: begin
                  state_d = view_state(~saved_q);
                  hold_d  = '0;
               end
`ifdef DISP_IDLE_BLANK_EN
               ST_BLANK: state_d = view_state(saved_q);
`endif
               default: state_d = ST_SW;
            endcase
         end
      end

      sel_d = sel_of(state_d);
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_SW;
         sel_q     <= SEL_SW;
         saved_q   <= 1'b0;
         hold_q    <= '0;
         alert_q   <= 1'b0;
         disp_en_q <= 1'b1;
`ifdef DISP_IDLE_BLANK_EN
         idle_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         saved_q   <= saved_d;
         hold_q    <= hold_d;
         alert_q   <= alert_d;
         disp_en_q <= disp_en_d;
`ifdef DISP_IDLE_BLANK_EN
         idle_q    <= idle_d;
`endif
      end
   end

   assign output_select = sel_q;
   assign alert         = alert_q;
   assign display_en    = disp_en_q;

endmodule
